// File: rtl/payload_engine_sched.sv
// payload_engine_sched: runs one packet at a time through a bank of parallel payload engines
// and serialises the sticky per-engine match bits as rule-index records plus a per-packet summary.
module payload_engine_sched #(
    parameter int NUM_ENGINES  = 64,
    parameter int IDX_W        = 6,
    parameter int DRAIN_CYCLES = 3,
    parameter int LEN_W        = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             s_data,
    input  logic                   s_valid,
    input  logic                   s_sop,
    input  logic                   s_eop,
    output logic                   s_ready,
    output logic [7:0]             eng_data,
    output logic                   eng_en,
    output logic                   eng_sod,
    input  logic [NUM_ENGINES-1:0] eng_match,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [IDX_W-1:0]       m_idx,
    output logic                   m_last,
    output logic                   m_any,
    output logic [LEN_W-1:0]       m_len,
    output logic [LEN_W-1:0]       drop_cnt,
    output logic                   busy
);
    localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ENGINES - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, SCAN, SUMMARY} state_t;

    state_t                 state;
    logic                   sod_q;
    logic [NUM_ENGINES-1:0] snap;
    logic [IDX_W-1:0]       ptr;
    logic [CNT_W-1:0]       cnt;
    logic                   step;

    assign s_ready  = rst_n & ((state == IDLE) ? ~s_sop : (state == STREAM));
    assign eng_en   = (state == STREAM) & s_valid;
    assign eng_data = s_data;
    assign eng_sod  = ~rst_n | sod_q;
    assign busy     = (state != IDLE);
    // a pending record advances only on handshake; an empty slot advances immediately
    assign step     = m_valid ? m_ready : ~snap[ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sod_q    <= 1'b0;
            snap     <= '0;
            ptr      <= '0;
            cnt      <= '0;
            m_valid  <= 1'b0;
            m_idx    <= '0;
            m_last   <= 1'b0;
            m_any    <= 1'b0;
            m_len    <= '0;
            drop_cnt <= '0;
        end else begin
            sod_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (s_valid && s_sop) begin
                        state <= CLEAR;
                        sod_q <= 1'b1;
                    end else if (s_valid && drop_cnt != '1) begin
                        drop_cnt <= drop_cnt + 1'b1;
                    end
                end
                CLEAR: begin
                    m_len <= '0;
                    snap  <= '0;
                    state <= STREAM;
                end
                STREAM: begin
                    if (s_valid) begin
                        if (m_len != '1) m_len <= m_len + 1'b1;
                        if (s_eop) begin
                            cnt   <= '0;
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (cnt == CNT_LAST) begin
                        snap  <= eng_match;
                        ptr   <= '0;
                        state <= SCAN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SCAN: begin
                    if (m_valid && m_ready) m_valid <= 1'b0;
                    if (!m_valid && snap[ptr]) begin
                        m_valid <= 1'b1;
                        m_idx   <= ptr;
                        m_last  <= 1'b0;
                    end else if (step) begin
                        if (ptr == IDX_LAST) begin
                            m_valid <= 1'b1;
                            m_last  <= 1'b1;
                            m_idx   <= '0;
                            m_any   <= |snap;
                            state   <= SUMMARY;
                        end else begin
                            ptr <= ptr + 1'b1;
                        end
                    end
                end
                SUMMARY: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
